// File: rtl/moore_stim_sequencer.sv
// Plays a programmed list of (symbol, hold) entries into a Moore FSM and folds its output into a signature.
// a_out is registered (first symbol one edge after start); writes and starts are ignored while busy.
module moore_stim_sequencer #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4,
    parameter int LAT    = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en_in,
    input  logic [AW-1:0]     wr_addr_in,
    input  logic [2:0]        wr_sym_in,
    input  logic [HOLD_W-1:0] wr_hold_in,
    input  logic [AW:0]       len_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [2:0]        z_in,
    output logic [2:0]        a_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [AW-1:0]     step_out,
    output logic [7:0]        sig_out
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          a_q, a_d;
    logic [AW-1:0]       step_q, step_d;
    logic [7:0]          sig_q, sig_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [AW:0]         len_q, len_d;
    logic [2:0]          mem_sym_q  [DEPTH];
    logic [HOLD_W-1:0]   mem_hold_q [DEPTH];

    logic [AW:0]         len_clamp;
    logic [AW-1:0]       step_nxt;
    logic [7:0]          sig_fold;
    logic                busy;

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign a_out    = a_q;
    assign busy_out = busy;
    assign done_out = (state_q == ST_DONE);
    assign step_out = step_q;
    assign sig_out  = sig_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            step_q  <= '0;
            sig_q   <= '0;
            hold_q  <= '0;
            drain_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            step_q  <= step_d;
            sig_q   <= sig_d;
            hold_q  <= hold_d;
            drain_q <= drain_d;
            len_q   <= len_d;
        end
    end

    // Abort outranks a write, so a write is only taken when abort is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_sym_q[i]  <= '0;
                mem_hold_q[i] <= '0;
            end
        end else if (wr_en_in && !abort_in && !busy) begin
            mem_sym_q[wr_addr_in]  <= wr_sym_in;
            mem_hold_q[wr_addr_in] <= wr_hold_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        step_d    = step_q;
        sig_d     = sig_q;
        hold_d    = hold_q;
        drain_d   = drain_q;
        len_d     = len_q;
        len_clamp = (len_in > DEPTH_L) ? DEPTH_L : len_in;
        step_nxt  = step_q + 1'b1;
        sig_fold  = {sig_q[6:0], sig_q[7]} ^ {5'b0, z_in};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                a_d = '0;
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (!wr_en_in && start_in) begin
                    sig_d = '0;
                    len_d = len_clamp;
                    if (len_clamp == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        step_d  = '0;
                        a_d     = mem_sym_q[0];
                        hold_d  = mem_hold_q[0];
                    end
                end
            end
            ST_RUN: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                    a_d     = '0;
                end else begin
                    sig_d = sig_fold;
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if ({1'b0, step_q} == len_q - 1'b1) begin
                        state_d = ST_DRAIN;
                        a_d     = '0;
                        drain_d = DRAIN_INIT;
                    end else begin
                        step_d = step_nxt;
                        a_d    = mem_sym_q[step_nxt];
                        hold_d = mem_hold_q[step_nxt];
                    end
                end
            end
            ST_DRAIN: begin
                a_d = '0;
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else begin
                    sig_d = sig_fold;
                    if (drain_q == '0) state_d = ST_DONE;
                    else               drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
